// File: rtl/sfp_cage_ctrl.sv
// SFP cage control: synchronizes and debounces cage status pins and
// sequences TX_DISABLE and GT channel reset through module bring-up.
module sfp_cage_ctrl #(
  parameter int DEB_CYCLES          = 100000,
  parameter int TXDIS_HOLD_CYCLES   = 1000,
  parameter int GT_RST_CYCLES       = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W               = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sfp_mod_abs,
  input  logic       sfp_rx_los,
  input  logic       sfp_tx_fault,
  input  logic       gt_reset_done,
  input  logic       pcs_link_up,
  output logic       sfp_tx_disable,
  output logic       gt_reset,
  output logic       link_ready,
  output logic [2:0] state,
  output logic [7:0] retry_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_GTRST = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_UP    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TXDIS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GT_LAST   = CNT_W'(GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  // bit 0 = mod_abs, bit 1 = rx_los, bit 2 = tx_fault
  localparam logic [2:0] PIN_RST = 3'b011;

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       deb_q, deb_d;
  logic [CNT_W-1:0] dcnt_q [3];
  logic [CNT_W-1:0] dcnt_d [3];
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       retry_q, retry_d;
  logic             txdis_q, txdis_d;
  logic             gtrst_q, gtrst_d;
  logic             ready_q, ready_d;

  logic mod_abs_deb, rx_los_deb, tx_fault_deb;

  assign mod_abs_deb  = deb_q[0];
  assign rx_los_deb   = deb_q[1];
  assign tx_fault_deb = deb_q[2];

  // Two-flop synchronizers, then a per-pin stability counter that flips
  // the debounced value after DEB_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d = {sfp_tx_fault, sfp_rx_los, sfp_mod_abs};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Bring-up FSM with global module-absent and fault overrides; outputs
  // are decoded from the next state so they register with the state.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (mod_abs_deb) begin
      state_d = S_IDLE;
    end else if (tx_fault_deb && state_q != S_IDLE) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_HOLD;
        S_HOLD:  if (timer_q == HOLD_LAST) state_d = S_GTRST;
        S_GTRST: if (timer_q == GT_LAST) state_d = S_WAIT;
        S_WAIT: begin
          if (gt_reset_done && !rx_los_deb && pcs_link_up) begin
            state_d = S_UP;
          end else if (timer_q == LOCK_LAST) begin
            state_d = S_GTRST;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end
        end
        S_UP: begin
          if (rx_los_deb || !pcs_link_up || !gt_reset_done) begin
            state_d = S_WAIT;
          end
        end
        S_FAULT: state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_IDLE) retry_d = 8'd0;

    timer_d = '0;
    if (state_d == state_q &&
        (state_q == S_HOLD || state_q == S_GTRST || state_q == S_WAIT)) begin
      timer_d = timer_q + CNT_W'(1);
    end

    txdis_d = (state_d == S_IDLE) || (state_d == S_HOLD) ||
              (state_d == S_FAULT);
    gtrst_d = txdis_d || (state_d == S_GTRST);
    ready_d = (state_d == S_UP);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= PIN_RST;
      sync2_q <= PIN_RST;
      deb_q   <= PIN_RST;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= 8'd0;
      txdis_q <= 1'b1;
      gtrst_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      txdis_q <= txdis_d;
      gtrst_q <= gtrst_d;
      ready_q <= ready_d;
    end
  end

  assign sfp_tx_disable = txdis_q;
  assign gt_reset       = gtrst_q;
  assign link_ready     = ready_q;
  assign state          = state_q;
  assign retry_count    = retry_q;

endmodule
